// File: rtl/as_arb_pkg.sv
// Shared definitions for the anti-spoof input arbiter: FSM encodings,
// default source-port header ctrl value and the end-of-packet ctrl test.
package as_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_IN_HDR = 3'b010,
    ST_IN_PKT = 3'b100
  } arb_state_t;

  localparam int unsigned ARB_IO_QUEUE_STAGE_NUM = 2;
  localparam int unsigned ARB_MAX_CTRL_WIDTH     = 32;

  // Any non-zero ctrl marks a header word, or EOP when it follows payload.
  function automatic logic ctrl_is_nonzero(input logic [ARB_MAX_CTRL_WIDTH-1:0] ctrl);
    return |ctrl;
  endfunction

endpackage

// File: rtl/as_rr_pick.sv
// Rotating-priority encoder: first asserted request at or above i_rr_ptr,
// wrapping at NUM_QUEUES.
module as_rr_pick #(
  parameter int unsigned NUM_QUEUES  = 8,
  parameter int unsigned NUM_IQ_BITS = 3
) (
  input  logic [NUM_QUEUES-1:0]  i_req,
  input  logic [NUM_IQ_BITS-1:0] i_rr_ptr,
  output logic [NUM_IQ_BITS-1:0] o_idx_c,
  output logic                   o_valid_c
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin : pick
    int unsigned cand;
    cand      = 0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      cand = 32'(i_rr_ptr) + 32'(k);
      if (cand >= NUM_QUEUES) cand = cand - NUM_QUEUES;
      if (i_req[NUM_IQ_BITS'(cand)]) begin
        o_idx_c   = NUM_IQ_BITS'(cand);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/as_input_arbiter_32bit.sv
// Round-robin packet arbiter from NUM_QUEUES FWFT FIFOs onto one stream.
// Optional source-port stamping of the header word: AS_INPUT_ARB_SRC_PORT_STAMP_EN.
module as_input_arbiter_32bit
  import as_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned NUM_QUEUES         = 8,
  parameter int unsigned NUM_IQ_BITS        = 3,
  parameter int unsigned IO_QUEUE_STAGE_NUM = ARB_IO_QUEUE_STAGE_NUM
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data_flat,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl_flat,
  input  logic [NUM_QUEUES-1:0]            in_empty,
  output logic [NUM_QUEUES-1:0]            in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [NUM_IQ_BITS-1:0]           grant
);

`ifdef AS_INPUT_ARB_SRC_PORT_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_IQ_BITS-1:0] r_grant, w_grant_nxt;
  logic [NUM_IQ_BITS-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [CTRL_WIDTH-1:0]  r_out_ctrl;
  logic                   r_out_wr;

  logic [DATA_WIDTH-1:0]  w_data_arr [NUM_QUEUES];
  logic [CTRL_WIDTH-1:0]  w_ctrl_arr [NUM_QUEUES];
  logic [DATA_WIDTH-1:0]  w_head_data, w_out_data;
  logic [CTRL_WIDTH-1:0]  w_head_ctrl;
  logic                   w_head_nonzero;
  logic                   w_pop;
  logic [NUM_IQ_BITS-1:0] w_pick_idx;
  logic                   w_pick_valid;

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_unpack
    assign w_data_arr[gi] = in_data_flat[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_ctrl_arr[gi] = in_ctrl_flat[gi*CTRL_WIDTH +: CTRL_WIDTH];
  end

  assign w_head_data    = w_data_arr[r_grant];
  assign w_head_ctrl    = w_ctrl_arr[r_grant];
  assign w_head_nonzero = ctrl_is_nonzero(ARB_MAX_CTRL_WIDTH'(w_head_ctrl));

  as_rr_pick #(
    .NUM_QUEUES  (NUM_QUEUES),
    .NUM_IQ_BITS (NUM_IQ_BITS)
  ) u_rr_pick (
    .i_req     (~in_empty),
    .i_rr_ptr  (r_rr_ptr),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  // Source-port header word carries the granted queue in its low bits.
  always_comb begin
    w_out_data = w_head_data;
    if (STAMP_EN && (w_head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM)))
      w_out_data[NUM_IQ_BITS-1:0] = r_grant;
  end

  // Next state, pop strobe and rotation pointer.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_pop        = 1'b0;
    in_rd_en     = '0;

    if ((r_state != ST_IDLE) && !reset)
      w_pop = !in_empty[r_grant] && out_rdy;
    if (w_pop)
      in_rd_en[r_grant] = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = ST_IN_HDR;
        end
      end
      ST_IN_HDR: begin
        if (w_pop && !w_head_nonzero)
          w_state_nxt = ST_IN_PKT;
      end
      ST_IN_PKT: begin
        if (w_pop && w_head_nonzero) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = (r_grant == NUM_IQ_BITS'(NUM_QUEUES - 1)) ?
                         '0 : r_grant + NUM_IQ_BITS'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Output word register; holds its value between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
      r_out_ctrl <= '0;
      r_out_wr   <= 1'b0;
    end else begin
      r_out_wr <= w_pop;
      if (w_pop) begin
        r_out_data <= w_out_data;
        r_out_ctrl <= w_head_ctrl;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_ctrl = r_out_ctrl;
  assign out_wr   = r_out_wr;
  assign grant    = r_grant;

endmodule

// File: tb/tb_as_input_arbiter_32bit.sv
// Directed scoreboard bench for as_input_arbiter_32bit: FIFO model per queue,
// expected words queued in required serve order and checked on each out_wr.
module tb_as_input_arbiter_32bit;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned NQ    = 8;
  localparam int unsigned NB    = 3;
  localparam int unsigned DEPTH = 64;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } word_t;

  typedef struct {
    int            src;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NQ*DW-1:0] in_data_flat;
  logic [NQ*CW-1:0] in_ctrl_flat;
  logic [NQ-1:0]    in_empty;
  logic [NQ-1:0]    in_rd_en;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic [NB-1:0]    grant;

  word_t   mem [NQ][DEPTH];
  int      rd_ptr [NQ];
  int      wr_ptr [NQ];
  exp_t    exp_q [$];
  int      total = 0;
  int      bad   = 0;
  int      wr_cnt;
  int      step_no;
  logic [NQ-1:0] last_rd;
  logic    last_wr;

  as_input_arbiter_32bit dut (
    .clk          (clk),
    .reset        (reset),
    .in_data_flat (in_data_flat),
    .in_ctrl_flat (in_ctrl_flat),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .grant        (grant)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input int src, input logic [CW-1:0] c,
                                             input logic [DW-1:0] d);
`ifdef AS_INPUT_ARB_SRC_PORT_STAMP_EN
    if (c == 4'd2) return {d[DW-1:NB], NB'(src)};
`endif
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NQ; i++) begin
      in_empty[i] = (rd_ptr[i] >= wr_ptr[i]);
      if (in_empty[i]) begin
        in_data_flat[i*DW +: DW] = '0;
        in_ctrl_flat[i*CW +: CW] = '0;
      end else begin
        in_data_flat[i*DW +: DW] = mem[i][rd_ptr[i]].data;
        in_ctrl_flat[i*CW +: CW] = mem[i][rd_ptr[i]].ctrl;
      end
    end
  endtask

  task automatic push_word(input int q, input logic [CW-1:0] c, input logic [DW-1:0] d,
                           input bit to_fifo, input bit to_exp);
    exp_t e;
    if (to_fifo) begin
      mem[q][wr_ptr[q]] = '{ctrl: c, data: d};
      wr_ptr[q]++;
    end
    if (to_exp) begin
      e.src  = q;
      e.ctrl = c;
      e.data = exp_data(q, c, d);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_pkt(input int q, input logic [CW-1:0] hc, input logic [DW-1:0] hd,
                          input int npay, input logic [DW-1:0] base,
                          input bit to_fifo, input bit to_exp);
    push_word(q, hc, hd, to_fifo, to_exp);
    for (int k = 0; k < npay; k++) push_word(q, 4'h0, base + 32'(k), to_fifo, to_exp);
    push_word(q, 4'hF, base + 32'h0000_00EE, to_fifo, to_exp);
    drive_inputs();
  endtask

  // One clock: sample pop strobes mid-cycle, apply pops, check the output word.
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_rd = in_rd_en;
    chk("rd_en_onehot", 32'($countones(last_rd) <= 1), 32'd1);
    for (int i = 0; i < NQ; i++)
      if (last_rd[i]) chk("rd_en_on_empty", 32'(in_empty[i]), 32'd0);
    @(posedge clk);
    #1;
    step_no++;
    for (int i = 0; i < NQ; i++)
      if (last_rd[i]) rd_ptr[i]++;
    drive_inputs();
    last_wr = out_wr;
    if (out_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
        chk("grant_on_wr", 32'(grant), 32'(e.src));
      end
    end
  endtask

  task automatic run_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    int n;
    int first_wr;
    clk = 1'b0;
    reset = 1'b1;
    out_rdy = 1'b1;
    wr_cnt = 0;
    step_no = 0;
    for (int i = 0; i < NQ; i++) begin
      rd_ptr[i] = 0;
      wr_ptr[i] = 0;
    end
    drive_inputs();

    // Reset state
    step();
    step();
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rd_en", 32'(last_rd), 32'd0);
    reset = 1'b0;

    // Single packet from queue 3
    load_pkt(3, 4'h2, 32'h0000_0003, 3, 32'h3000_0010, 1'b1, 1'b1);
    wr_cnt = 0;
    step_no = 0;
    first_wr = 0;
    step();
    chk("arb_no_pop", 32'(last_rd), 32'd0);
    chk("arb_grant", 32'(grant), 32'd3);
    while (exp_q.size() != 0 && step_no < 50) begin
      step();
      if (last_wr && first_wr == 0) first_wr = step_no;
    end
    chk("single_first_wr_step", 32'(first_wr), 32'd2);
    chk("single_wr_count", 32'(wr_cnt), 32'd5);
    chk("single_grant", 32'(grant), 32'd3);
    chk("single_drain", 32'(exp_q.size()), 32'd0);

    // Fairness across queues 0, 1, 5 with two packets each
    do_reset();
    load_pkt(0, 4'h1, 32'h0A00_0000, 2, 32'h0A00_0100, 1'b1, 1'b1);
    load_pkt(1, 4'h1, 32'h0B00_0000, 2, 32'h0B00_0100, 1'b1, 1'b1);
    load_pkt(5, 4'h1, 32'h0C00_0000, 2, 32'h0C00_0100, 1'b1, 1'b1);
    load_pkt(0, 4'h1, 32'h0A10_0000, 2, 32'h0A10_0100, 1'b1, 1'b1);
    load_pkt(1, 4'h1, 32'h0B10_0000, 2, 32'h0B10_0100, 1'b1, 1'b1);
    load_pkt(5, 4'h1, 32'h0C10_0000, 2, 32'h0C10_0100, 1'b1, 1'b1);
    wr_cnt = 0;
    run_drain(100);
    chk("fair_wr_count", 32'(wr_cnt), 32'd24);

    // Backpressure mid-payload on queue 7
    load_pkt(7, 4'h1, 32'h7000_0000, 6, 32'h7000_0100, 1'b1, 1'b1);
    wr_cnt = 0;
    n = 0;
    while (wr_cnt < 3 && n < 20) begin
      step();
      n++;
    end
    chk("bp_reach_payload", 32'(wr_cnt), 32'd3);
    out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_rd_en", 32'(last_rd), 32'd0);
      chk("bp_out_wr", 32'(last_wr), 32'd0);
    end
    out_rdy = 1'b1;
    run_drain(40);
    chk("bp_wr_count", 32'(wr_cnt), 32'd8);

    // Queue 2 runs dry mid-packet while queue 4 waits
    push_word(2, 4'h1, 32'h2000_0000, 1'b1, 1'b1);
    push_word(2, 4'h0, 32'h2000_0100, 1'b1, 1'b1);
    push_word(2, 4'h0, 32'h2000_0101, 1'b1, 1'b1);
    load_pkt(4, 4'h1, 32'h4000_0000, 2, 32'h4000_0100, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("stall_grant", 32'(grant), 32'd2);
    end
    chk("stall_q4_untouched", 32'(rd_ptr[4]), 32'd0);
    chk("stall_q2_words", 32'(exp_q.size()), 32'd0);
    push_word(2, 4'h0, 32'h2000_0102, 1'b1, 1'b1);
    push_word(2, 4'hF, 32'h2000_00EE, 1'b1, 1'b1);
    load_pkt(4, 4'h1, 32'h4000_0000, 2, 32'h4000_0100, 1'b0, 1'b1);
    run_drain(40);
    chk("stall_then_q4", 32'(grant), 32'd4);

    // Source-port stamp on queue 6 header
    load_pkt(6, 4'h2, 32'hABCD_0000, 1, 32'h6000_0100, 1'b1, 1'b1);
    n = 0;
    last_wr = 1'b0;
    while (!last_wr && n < 10) begin
      step();
      n++;
    end
`ifdef AS_INPUT_ARB_SRC_PORT_STAMP_EN
    chk("stamp_hdr", out_data, 32'hABCD_0006);
`else
    chk("stamp_hdr", out_data, 32'hABCD_0000);
`endif
    run_drain(20);

    // Reset while queue 5 is mid-payload
    load_pkt(5, 4'h1, 32'h5000_0000, 5, 32'h5000_0100, 1'b1, 1'b1);
    wr_cnt = 0;
    n = 0;
    while (wr_cnt < 3 && n < 20) begin
      step();
      n++;
    end
    chk("rstmid_reach_payload", 32'(wr_cnt), 32'd3);
    reset = 1'b1;
    exp_q.delete();
    step();
    chk("rstmid_rd_en", 32'(last_rd), 32'd0);
    chk("rstmid_out_wr", 32'(out_wr), 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    load_pkt(0, 4'h1, 32'h0E00_0000, 1, 32'h0E00_0100, 1'b1, 1'b1);
    load_pkt(3, 4'h1, 32'h3E00_0000, 1, 32'h3E00_0100, 1'b1, 1'b1);
    for (int k = rd_ptr[5]; k < wr_ptr[5]; k++)
      push_word(5, mem[5][k].ctrl, mem[5][k].data, 1'b0, 1'b1);
    step();
    chk("rstmid_idle_no_pop", 32'(last_rd), 32'd0);
    chk("rstmid_restart_q0", 32'(grant), 32'd0);
    run_drain(80);
    chk("rstmid_last_grant", 32'(grant), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
